alu_sequencer: RTL and testbench

Instruction-issuing controller that drives the 8-bit ALU's OP/A/B inputs and consumes its Z result. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x8 register file. It presents the operands to the ALU, captures Z, writes Z back to the destination register and reports the result. It is the first piece of the datapath control for the Project 1 processor.

---
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to the external 8-bit ALU.
// Operands come from a 4x8 register file. The ALU result is written back to
// the destination register and reported on RESULT with a one-cycle pulse.
module alu_sequencer #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        NREG     = 4,
  parameter logic [DATA_W-1:0]  REG_INIT = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              INSTR_VALID,
  input  logic [15:0]       INSTR,
  output logic              INSTR_READY,
  output logic [3:0]        ALU_OP,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  input  logic [DATA_W-1:0] ALU_Z,
  output logic              RESULT_VALID,
  output logic [DATA_W-1:0] RESULT,
  output logic [1:0]        RESULT_RD,
  output logic              ERR,
  input  logic [1:0]        DBG_SEL,
  output logic [DATA_W-1:0] DBG_DATA
);

  localparam logic [3:0] OP_IMM  = 4'hF;
  localparam logic [3:0] OP_LAST = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [DATA_W-1:0]  r_regs [NREG];
  logic [3:0]         r_alu_op;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [DATA_W-1:0]  r_result;
  logic [1:0]         r_result_rd;
  logic [1:0]         r_rd;
  logic               r_legal;

  logic               w_instr_ready;
  logic               w_accept;
  logic               w_exec_write;
  logic               w_result_valid;
  logic               w_err;

  logic [3:0]         w_op;
  logic [1:0]         w_rd;
  logic [1:0]         w_ra;
  logic [1:0]         w_rb;
  logic [DATA_W-1:0]  w_imm;
  logic               w_legal_op;

  // Instruction field decode; opcodes 1010..1110 are rejected with ERR
  assign w_op       = INSTR[15:12];
  assign w_rd       = INSTR[11:10];
  assign w_ra       = INSTR[9:8];
  assign w_rb       = INSTR[7:6];
  assign w_imm      = DATA_W'(INSTR[7:0]);
  assign w_legal_op = (w_op <= OP_LAST) || (w_op == OP_IMM);
  assign w_accept   = w_instr_ready & INSTR_VALID;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: fixed IDLE -> EXEC -> WB -> IDLE walk
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from state; ready is forced low while reset is held
  always_comb begin
    w_instr_ready  = 1'b0;
    w_exec_write   = 1'b0;
    w_result_valid = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      S_IDLE: w_instr_ready = RST_N;
      S_EXEC: w_exec_write  = r_legal;
      S_WB: begin
        w_result_valid = r_legal;
        w_err          = ~r_legal;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, writeback of ALU_Z at end of EXEC
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_alu_op    <= 4'b0000;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_result    <= '0;
      r_result_rd <= 2'b00;
      r_rd        <= 2'b00;
      r_legal     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= REG_INIT;
    end else begin
      if (w_accept) begin
        r_alu_op <= w_op;
        r_alu_a  <= r_regs[w_ra];
        r_alu_b  <= (w_op == OP_IMM) ? w_imm : r_regs[w_rb];
        r_rd     <= w_rd;
        r_legal  <= w_legal_op;
      end
      if (w_exec_write) begin
        r_result     <= ALU_Z;
        r_result_rd  <= r_rd;
        r_regs[r_rd] <= ALU_Z;
      end
    end
  end

  assign INSTR_READY  = w_instr_ready;
  assign ALU_OP       = r_alu_op;
  assign ALU_A        = r_alu_a;
  assign ALU_B        = r_alu_b;
  assign RESULT_VALID = w_result_valid;
  assign ERR          = w_err;
  assign RESULT       = r_result;
  assign RESULT_RD    = r_result_rd;
  assign DBG_DATA     = r_regs[DBG_SEL];

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed cases plus randomized instructions,
// with a queue-based scoreboard checked by an independent output monitor.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        INSTR_VALID;
  logic [15:0] INSTR;
  logic        INSTR_READY;
  logic [3:0]  ALU_OP;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [7:0]  ALU_Z;
  logic        RESULT_VALID;
  logic [7:0]  RESULT;
  logic [1:0]  RESULT_RD;
  logic        ERR;
  logic [1:0]  DBG_SEL;
  logic [7:0]  DBG_DATA;

  alu_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .INSTR_VALID(INSTR_VALID), .INSTR(INSTR),
    .INSTR_READY(INSTR_READY), .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_Z(ALU_Z), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT),
    .RESULT_RD(RESULT_RD), .ERR(ERR), .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // Bench ALU: opcode 1111 passes B through (load immediate)
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return 8'((int'(a) + int'(b)) % 256);
      4'h3: return 8'((256 - int'(a)) % 256);
      4'h4: return 8'((int'(a) - int'(b) + 256) % 256);
      4'h5: return a ^ b;
      4'h6: return 8'((int'(a) * 2) % 256);
      4'h7: return 8'(int'(a) / 2);
      4'h8: return (a == b) ? 8'h01 : 8'h00;
      4'h9: return (a > b) ? 8'h01 : 8'h00;
      4'hF: return b;
      default: return 8'hEE;
    endcase
  endfunction

  assign ALU_Z = alu_fn(ALU_OP, ALU_A, ALU_B);

  typedef struct {
    bit         is_err;
    logic [1:0] rd;
    logic [7:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mregs [4];
  logic [7:0]  mres;
  logic [1:0]  mrd;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          last_acc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mres = 8'h00;
    mrd  = 2'b00;
  endtask

  // Monitor: every RESULT_VALID/ERR cycle must match the oldest expectation
  always @(negedge CLK) begin
    if (RESULT_VALID === 1'b1 || ERR === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {30'd0, RESULT_VALID, ERR}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_valid", 32'(RESULT_VALID), 32'(!e.is_err));
        chk("err", 32'(ERR), 32'(e.is_err));
        chk("result", 32'(RESULT), 32'(e.val));
        chk("result_rd", 32'(RESULT_RD), 32'(e.rd));
      end
    end
  end

  // Present an instruction (called at a negedge); model updates at the accept edge
  task automatic issue(input logic [15:0] ins, input bit hold_valid);
    logic [3:0] op;
    logic [7:0] a, b, v;
    bit got = 0;
    INSTR = ins;
    INSTR_VALID = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (INSTR_READY === 1'b1) begin got = 1; break; end
      @(negedge CLK);
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=ready_low expected=ready_high (t=%0t)", $time);
      INSTR_VALID = 1'b0;
      return;
    end
    op = ins[15:12];
    a  = mregs[ins[9:8]];
    b  = (op == 4'hF) ? ins[7:0] : mregs[ins[7:6]];
    if (op <= 4'h9 || op == 4'hF) begin
      v = alu_fn(op, a, b);
      mregs[ins[11:10]] = v;
      mres = v;
      mrd  = ins[11:10];
      sb.push_back('{is_err: 1'b0, rd: ins[11:10], val: v});
    end else begin
      sb.push_back('{is_err: 1'b1, rd: mrd, val: mres});
    end
    @(posedge CLK);
    #1;
    last_acc = cyc;
    chk("alu_op", 32'(ALU_OP), 32'(op));
    chk("alu_a", 32'(ALU_A), 32'(a));
    chk("alu_b", 32'(ALU_B), 32'(b));
    chk("ready_after_accept", 32'(INSTR_READY), 32'd0);
    if (!hold_valid) begin
      INSTR_VALID = 1'b0;
      INSTR = 16'($urandom);
    end
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (INSTR_READY === 1'b1 && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=pending%0d expected=pending0 (t=%0t)", sb.size(), $time);
    end
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 4; i++) begin
      DBG_SEL = 2'(i);
      #1;
      chk($sformatf("dbg_reg%0d", i), 32'(DBG_DATA), 32'(mregs[i]));
    end
  endtask

  function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 6'b000000};
  endfunction

  function automatic logic [15:0] mk_i(input logic [1:0] rd, input logic [7:0] imm);
    return {4'hF, rd, 2'b00, imm};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu_op"}, 32'(ALU_OP), 32'd0);
    chk({tag, "_alu_a"}, 32'(ALU_A), 32'd0);
    chk({tag, "_alu_b"}, 32'(ALU_B), 32'd0);
    chk({tag, "_result"}, 32'(RESULT), 32'd0);
    chk({tag, "_result_rd"}, 32'(RESULT_RD), 32'd0);
    chk({tag, "_rv_err"}, {30'd0, RESULT_VALID, ERR}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    RST_N = 1'b0; INSTR_VALID = 1'b0; INSTR = 16'h0000; DBG_SEL = 2'b00;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("ready_in_reset", 32'(INSTR_READY), 32'd0);
    check_reset_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    dbg_sweep();
    @(negedge CLK);

    // Load immediate and read it back through the debug port
    issue(mk_i(2'd1, 8'h05), 0);
    wait_idle();
    dbg_sweep();

    // Wrapping add, then negate of the stored sum
    issue(mk_i(2'd2, 8'hFE), 0);
    issue(mk_r(4'h2, 2'd3, 2'd1, 2'd2), 0);
    issue(mk_r(4'h3, 2'd0, 2'd3, 2'd0), 0);
    wait_idle();
    chk("add_wrap_reg3", 32'(mregs[3]), 32'h03);
    dbg_sweep();

    // Back-to-back dependent pair with valid held high
    issue(mk_i(2'd0, 8'h01), 1);
    gap = last_acc;
    issue(mk_r(4'h6, 2'd0, 2'd0, 2'd0), 0);
    chk("accept_gap", 32'(last_acc - gap), 32'd3);
    wait_idle();
    dbg_sweep();

    // Illegal opcode: ERR pulse only, nothing written
    issue(mk_r(4'hA, 2'd2, 2'd1, 2'd1), 0);
    wait_idle();
    dbg_sweep();

    // Reset during EXEC aborts the write
    issue(mk_i(2'd3, 8'hAA), 0);
    RST_N = 1'b0;
    void'(sb.pop_back());
    model_reset();
    @(posedge CLK); #1;
    chk("ready_in_reset2", 32'(INSTR_READY), 32'd0);
    @(posedge CLK); #1;
    chk("ready_in_reset3", 32'(INSTR_READY), 32'd0);
    check_reset_outputs("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_release", 32'(INSTR_READY), 32'd1);
    dbg_sweep();
    @(negedge CLK);

    // Equality and unsigned greater-than
    issue(mk_i(2'd1, 8'h05), 0);
    issue(mk_i(2'd2, 8'hFE), 0);
    issue(mk_r(4'h8, 2'd3, 2'd1, 2'd1), 0);
    issue(mk_r(4'h9, 2'd0, 2'd1, 2'd2), 0);
    wait_idle();
    dbg_sweep();

    // Randomized instruction stream with random gaps and held valid
    for (int n = 0; n < 80; n++) begin
      issue(16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    wait_idle();
    dbg_sweep();
    chk("final_result", 32'(RESULT), 32'(mres));
    chk("final_result_rd", 32'(RESULT_RD), 32'(mrd));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
